// File: rtl/regfile_alu_pipe_if.sv
// Operation/result bundle between the instruction decoder (master) and the
// register-file/ALU pipeline (slave), plus the debug register read port.
interface regfile_alu_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              W;
  logic [ADDR_W-1:0] SA;
  logic [ADDR_W-1:0] SB;
  logic [ADDR_W-1:0] DA;
  logic [4:0]        FS;
  logic              C0;
  logic [DATA_W-1:0] K;
  logic              K_SEL;
  logic              EN_ALU;
  logic              EN_B;
  logic              out_valid;
  logic [DATA_W-1:0] result;
  logic [3:0]        Status;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output in_valid, W, SA, SB, DA, FS, C0, K, K_SEL, EN_ALU, EN_B, dbg_addr,
    input  out_valid, result, Status, dbg_data
  );

  modport slave (
    input  in_valid, W, SA, SB, DA, FS, C0, K, K_SEL, EN_ALU, EN_B, dbg_addr,
    output out_valid, result, Status, dbg_data
  );
endinterface

// File: rtl/regfile_alu_pipe.sv
// Two-stage register-file + ALU pipeline: READ (stage 1), then EXEC/WB (stage 2).
// Optional macro FORWARD_EN bypasses the stage-2 writeback value into stage-1 capture.
module regfile_alu_pipe #(
  parameter int DATA_W    = 64,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  regfile_alu_pipe_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_COUNT - 1);

  logic [DATA_W-1:0] regs [REG_COUNT];

  logic              vld_p1, w_p1, c0_p1, en_alu_p1, en_b_p1;
  logic [DATA_W-1:0] a_p1, b_p1;
  logic [4:0]        fs_p1;
  logic [ADDR_W-1:0] da_p1;

  logic              out_vld_p2;
  logic [DATA_W-1:0] result_p2;
  logic [3:0]        status_p2;

  logic [DATA_W-1:0] rf_a, rf_b, opnd_a, opnd_b;
  logic [DATA_W-1:0] alu_y, wb_val;
  logic              alu_c, alu_v, src_alu, src_b, wr_en;

  function automatic void alu_eval(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        fs,
    input  logic              c0,
    output logic [DATA_W-1:0] y,
    output logic              c,
    output logic              v
  );
    logic [DATA_W-1:0] ai, bi;
    logic [DATA_W:0]   sum;
    ai  = fs[0] ? ~a : a;
    bi  = fs[1] ? ~b : b;
    sum = {1'b0, ai} + {1'b0, bi} + {{DATA_W{1'b0}}, c0};
    c   = 1'b0;
    v   = 1'b0;
    case (fs[4:2])
      3'b000: y = ai & bi;
      3'b001: y = ai | bi;
      3'b010: begin
        y = sum[DATA_W-1:0];
        c = sum[DATA_W];
        v = (ai[DATA_W-1] == bi[DATA_W-1]) && (sum[DATA_W-1] != ai[DATA_W-1]);
      end
      3'b011: y = ai ^ bi;
      3'b100: y = ai << bi[SH_W-1:0];
      3'b101: y = ai >> bi[SH_W-1:0];
      default: y = bi;
    endcase
  endfunction

  // The hard-zero register is masked on every read path rather than trusted to stay 0.
  always_comb begin
    rf_a         = (bus.SA == ZERO_REG) ? '0 : regs[bus.SA];
    rf_b         = (bus.SB == ZERO_REG) ? '0 : regs[bus.SB];
    bus.dbg_data = (bus.dbg_addr == ZERO_REG) ? '0 : regs[bus.dbg_addr];
  end

  always_comb begin
    alu_eval(a_p1, b_p1, fs_p1, c0_p1, alu_y, alu_c, alu_v);
    src_alu = en_alu_p1 & ~en_b_p1;
    src_b   = en_b_p1 & ~en_alu_p1;
    wb_val  = src_alu ? alu_y : (src_b ? b_p1 : '0);
    wr_en   = vld_p1 & w_p1 & (src_alu | src_b) & (da_p1 != ZERO_REG);
  end

`ifdef FORWARD_EN
  always_comb begin
    opnd_a = (wr_en && (da_p1 == bus.SA)) ? wb_val : rf_a;
    opnd_b = bus.K_SEL ? bus.K : ((wr_en && (da_p1 == bus.SB)) ? wb_val : rf_b);
  end
`else
  always_comb begin
    opnd_a = rf_a;
    opnd_b = bus.K_SEL ? bus.K : rf_b;
  end
`endif

  // ---- stage 1: operand read / capture ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      w_p1      <= 1'b0;
      c0_p1     <= 1'b0;
      en_alu_p1 <= 1'b0;
      en_b_p1   <= 1'b0;
      a_p1      <= '0;
      b_p1      <= '0;
      fs_p1     <= '0;
      da_p1     <= '0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        w_p1      <= bus.W;
        c0_p1     <= bus.C0;
        en_alu_p1 <= bus.EN_ALU;
        en_b_p1   <= bus.EN_B;
        a_p1      <= opnd_a;
        b_p1      <= opnd_b;
        fs_p1     <= bus.FS;
        da_p1     <= bus.DA;
      end
    end
  end

  // ---- stage 2: execute / writeback / retire ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      out_vld_p2 <= 1'b0;
      result_p2  <= '0;
      status_p2  <= '0;
    end else begin
      out_vld_p2 <= vld_p1;
      if (vld_p1) result_p2 <= wb_val;
      if (vld_p1 && src_alu)
        status_p2 <= {alu_v, alu_c, alu_y[DATA_W-1], (alu_y == '0)};
      if (wr_en) regs[da_p1] <= wb_val;
    end
  end

  assign bus.out_valid = out_vld_p2;
  assign bus.result    = result_p2;
  assign bus.Status    = status_p2;
endmodule
